// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST sliding-window patch scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fast_pkg;

   // Write-side FSM: which half of the row-FIFO bank the next beat lands in.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR_LO = 2'd1,
      ST_WR_HI = 2'd2
   } wr_state_e;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fast_swpb_rdctl.sv
// Read-side scheduler: pops all 8 row FIFOs together and tracks patch position.
// Latency: rd_en combinational; patch outputs registered one cycle after the valid_all beat.
// Backpressure: no read while any FIFO is empty or ds_ready is low; gaps hold all position state.
// Ports: fifo_empty/fifo_valid (FIFO status in), ds_ready (in), fifo_rd_en (out),
//        patch_valid, x_coord, y_coord, score_eol, frame_done (registered outputs).
module fast_swpb_rdctl
   import fast_pkg::*;
#(
   parameter int COL_NUM = 640,
   parameter int ROW_NUM = 480
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  fifo_empty,
   input  logic [7:0]                  fifo_valid,
   input  logic                        ds_ready,
   output logic                        fifo_rd_en,
   output logic                        patch_valid,
   output logic [clog2(COL_NUM)-1:0]   x_coord,
   output logic [clog2(ROW_NUM)-1:0]   y_coord,
   output logic                        score_eol,
   output logic                        frame_done
);

   localparam int CW = clog2(COL_NUM);
   localparam int RW = clog2(ROW_NUM);

   logic [CW-1:0] col_cnt;
   logic [RW-1:0] row_base;
   logic          valid_all;
   logic          col_last;
   logic          strip_last;

   // Gated by rst_n so the read strobe is quiet for the whole reset window.
   assign fifo_rd_en = rst_n & ds_ready & ~(|fifo_empty);
   assign valid_all  = &fifo_valid;
   assign col_last   = (col_cnt == CW'(COL_NUM - 1));
   assign strip_last = (row_base == RW'(ROW_NUM - 8));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt     <= '0;
         row_base    <= '0;
         patch_valid <= 1'b0;
         x_coord     <= '0;
         y_coord     <= '0;
         score_eol   <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         patch_valid <= 1'b0;
         score_eol   <= 1'b0;
         frame_done  <= 1'b0;
         if (valid_all) begin
            col_cnt <= col_last ? '0 : col_cnt + CW'(1);
            // Strips overlap by 6 rows: advance 2 rows per completed strip.
            if (col_last) row_base <= strip_last ? '0 : row_base + RW'(2);
            // A 7-wide window is complete once columns 0..6 have arrived;
            // the centre column lags the newest one by 3.
            if (col_cnt >= CW'(6)) begin
               patch_valid <= 1'b1;
               x_coord     <= col_cnt - CW'(3);
               y_coord     <= row_base + RW'(3);
            end
            score_eol  <= col_last;
            frame_done <= col_last & strip_last;
         end
      end
   end

endmodule

// File: rtl/fast_swpb_sched.sv
// Top: splits a 4-pixel AXIS stream across 8 row FIFOs and schedules column reads into patches.
// Latency: tready combinational; fifo_wr_en/fifo_din one cycle after handshake; patches per rdctl.
// Backpressure: tready drops while any FIFO in the targeted half is full; reads wait on ds_ready.
// Ports: s_axis_* (pixel stream), fifo_* (row FIFO bank control/status), ds_ready,
//        patch_valid/x_coord/y_coord/score_eol/frame_done (patch position).
// Option: define FAST_SWPB_SCHED_TLAST_CHECK_EN to add a sticky tlast_err output
//         flagging tlast not matching the last beat of a strip.
module fast_swpb_sched
   import fast_pkg::*;
#(
   parameter int COL_NUM = 640,
   parameter int ROW_NUM = 480
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [31:0]                 s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic                        s_axis_tready,
   input  logic [7:0]                  fifo_full,
   input  logic [7:0]                  fifo_empty,
   input  logic [7:0]                  fifo_valid,
   output logic [7:0]                  fifo_wr_en,
   output logic [31:0]                 fifo_din,
   output logic                        fifo_rd_en,
   input  logic                        ds_ready,
`ifdef FAST_SWPB_SCHED_TLAST_CHECK_EN
   output logic                        tlast_err,
`endif
   output logic                        patch_valid,
   output logic [clog2(COL_NUM)-1:0]   x_coord,
   output logic [clog2(ROW_NUM)-1:0]   y_coord,
   output logic                        score_eol,
   output logic                        frame_done
);

   localparam int BEATS = 2 * COL_NUM;
   localparam int BW    = clog2(BEATS);

   wr_state_e     state, state_nxt;
   logic          hs;
   logic [BW-1:0] beat_cnt;

   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_WR_LO;
         ST_WR_LO: begin
            s_axis_tready = ~(|fifo_full[3:0]);
            if (s_axis_tvalid && s_axis_tready) state_nxt = ST_WR_HI;
         end
         ST_WR_HI: begin
            s_axis_tready = ~(|fifo_full[7:4]);
            if (s_axis_tvalid && s_axis_tready) state_nxt = ST_WR_LO;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign hs = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         fifo_wr_en <= 8'h00;
         fifo_din   <= '0;
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         fifo_wr_en <= 8'h00;
         if (hs) begin
            // Even beats carry pixels for rows 0-3, odd beats for rows 4-7.
            fifo_wr_en <= (state == ST_WR_HI) ? 8'hF0 : 8'h0F;
            fifo_din   <= s_axis_tdata;
            beat_cnt   <= (beat_cnt == BW'(BEATS - 1)) ? '0 : beat_cnt + BW'(1);
         end
      end
   end

`ifdef FAST_SWPB_SCHED_TLAST_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tlast_err <= 1'b0;
      else if (hs && (s_axis_tlast != (beat_cnt == BW'(BEATS - 1)))) tlast_err <= 1'b1;
   end
`else
   logic unused_tlast;
   assign unused_tlast = s_axis_tlast;
`endif

   fast_swpb_rdctl #(
      .COL_NUM (COL_NUM),
      .ROW_NUM (ROW_NUM)
   ) u_rdctl (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty  (fifo_empty),
      .fifo_valid  (fifo_valid),
      .ds_ready    (ds_ready),
      .fifo_rd_en  (fifo_rd_en),
      .patch_valid (patch_valid),
      .x_coord     (x_coord),
      .y_coord     (y_coord),
      .score_eol   (score_eol),
      .frame_done  (frame_done)
   );

endmodule

// File: tb/tb_fast_swpb_sched.sv
// Randomized bench for fast_swpb_sched (COL_NUM=8, ROW_NUM=12) against a position-arithmetic model.
module tb_fast_swpb_sched;

   localparam int COL    = 8;
   localparam int ROW    = 12;
   localparam int CW     = 3;
   localparam int RW     = 4;
   localparam int NSTRIP = (ROW - 8) / 2 + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tready;
   logic [7:0]    fifo_full, fifo_empty, fifo_valid;
   logic [7:0]    fifo_wr_en;
   logic [31:0]   fifo_din;
   logic          fifo_rd_en;
   logic          ds_ready;
   logic          tlast_err;
   logic          patch_valid;
   logic [CW-1:0] x_coord;
   logic [RW-1:0] y_coord;
   logic          score_eol;
   logic          frame_done;

   always #5 clk = ~clk;

   fast_swpb_sched #(.COL_NUM(COL), .ROW_NUM(ROW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .fifo_valid    (fifo_valid),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_din      (fifo_din),
      .fifo_rd_en    (fifo_rd_en),
      .ds_ready      (ds_ready),
`ifdef FAST_SWPB_SCHED_TLAST_CHECK_EN
      .tlast_err     (tlast_err),
`endif
      .patch_valid   (patch_valid),
      .x_coord       (x_coord),
      .y_coord       (y_coord),
      .score_eol     (score_eol),
      .frame_done    (frame_done)
   );

`ifndef FAST_SWPB_SCHED_TLAST_CHECK_EN
   assign tlast_err = 1'b0;
`endif

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: counts of accepted beats and valid columns since reset.
   bit          started;
   int          hs_cnt;
   int          k;
   bit          last_rd;
   logic [7:0]  e_wr;
   logic [31:0] e_din;
   bit          e_pv, e_eol, e_fd, e_err;
   int          e_x, e_y;
   int          frames;

   task automatic model_reset();
      started = 0; hs_cnt = 0; k = 0; last_rd = 0;
      e_wr = 8'h00; e_din = 32'h0; e_pv = 0; e_eol = 0; e_fd = 0; e_err = 0;
      e_x = 0; e_y = 0;
   endtask

   // Assert reset asynchronously mid-cycle and check outputs clear at once.
   task automatic do_reset();
      ds_ready = 1'b1; fifo_empty = 8'h00; fifo_full = 8'h00; s_axis_tvalid = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_din", fifo_din, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_pv", patch_valid, 0);
      chk("rst_x", x_coord, 0);
      chk("rst_y", y_coord, 0);
      chk("rst_eol", score_eol, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_err", tlast_err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: called at a negedge, returns at the next negedge.
   task automatic cycle();
      bit exp_rdy, exp_rd;
      int col, rb;
      chk("wr_en", fifo_wr_en, e_wr);
      chk("din", fifo_din, e_din);
      chk("patch_valid", patch_valid, e_pv);
      chk("x_coord", x_coord, e_x);
      chk("y_coord", y_coord, e_y);
      chk("score_eol", score_eol, e_eol);
      chk("frame_done", frame_done, e_fd);
      chk("tlast_err", tlast_err, e_err);

      fifo_valid    = last_rd ? 8'hFF : 8'($urandom_range(0, 254));
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      fifo_full     = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      fifo_empty    = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      ds_ready      = ($urandom_range(0, 5) != 0);
      s_axis_tlast  = ((hs_cnt % (2 * COL)) == 2 * COL - 1);
`ifdef FAST_SWPB_SCHED_TLAST_CHECK_EN
      if ($urandom_range(0, 299) == 0) s_axis_tlast = ~s_axis_tlast;
`endif
      #1;
      exp_rdy = started && ((hs_cnt % 2 == 1) ? (fifo_full[7:4] == 0) : (fifo_full[3:0] == 0));
      exp_rd  = ds_ready && (fifo_empty == 8'h00);
      chk("tready", s_axis_tready, exp_rdy);
      chk("rd_en", fifo_rd_en, exp_rd);

      if (s_axis_tvalid && exp_rdy) begin
         e_wr  = (hs_cnt % 2 == 1) ? 8'hF0 : 8'h0F;
         e_din = s_axis_tdata;
`ifdef FAST_SWPB_SCHED_TLAST_CHECK_EN
         if (s_axis_tlast != ((hs_cnt % (2 * COL)) == 2 * COL - 1)) e_err = 1;
`endif
         hs_cnt++;
      end else begin
         e_wr = 8'h00;
      end

      if (fifo_valid == 8'hFF) begin
         col   = k % COL;
         rb    = 2 * ((k / COL) % NSTRIP);
         e_pv  = (col >= 6);
         if (col >= 6) begin
            e_x = col - 3;
            e_y = rb + 3;
         end
         e_eol = (col == COL - 1);
         e_fd  = e_eol && (rb == ROW - 8);
         if (e_fd) frames++;
         k++;
      end else begin
         e_pv = 0; e_eol = 0; e_fd = 0;
      end

      last_rd = exp_rd;
      started = 1;
      @(negedge clk);
   endtask

   initial begin
      frames        = 0;
      rst_n         = 1'b1;
      s_axis_tdata  = 32'h0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      fifo_full     = 8'h00;
      fifo_empty    = 8'hFF;
      fifo_valid    = 8'h00;
      ds_ready      = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();
      repeat (1500) cycle();
      do_reset();
      repeat (1500) cycle();
      if (frames == 0) chk("frames_seen", 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
